processor_operand_stage: RTL and testbench

PROCESSOR_OPERAND_STAGE -- requirements
Module: processor_operand_stage

---
 rtl/processor_operand_stage.sv | 175 +++++++++++++++++
 tb/tb_processor_operand_stage.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/processor_operand_stage.sv
// Operand fetch stage: decodes the instruction word, reads and bypasses
// register operands, and runs the data-memory access for load, store and call.
// Results are held in a one-entry output register with a valid/ready handshake.
package processor_operand_stage_pkg;
  localparam logic [3:0] OP_NOP              = 4'h0;
  localparam logic [3:0] OP_REG_ADD_IMM8     = 4'h1;
  localparam logic [3:0] OP_LOAD_FROM_MEMORY = 4'h2;
  localparam logic [3:0] OP_WRITE_TO_MEMORY  = 4'h3;
  localparam logic [3:0] OP_IF               = 4'h4;
  localparam logic [3:0] OP_CALL_IMM14       = 4'h5;
endpackage

module processor_operand_stage
  import processor_operand_stage_pkg::*;
#(
  parameter int ADDR_SIZE = 18,
  parameter int WORD_SIZE = 18,
  parameter int REG_BITS  = 3,
  parameter int IMM_BITS  = 8,
  parameter int SP_REG    = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  // upstream
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ADDR_SIZE-1:0] in_ip,
  input  logic [WORD_SIZE-1:0] in_code_word,
  input  logic                 flush,
  // register file
  output logic [REG_BITS-1:0]  reg_read_addr0,
  output logic [REG_BITS-1:0]  reg_read_addr1,
  input  logic [WORD_SIZE-1:0] reg_read_data0,
  input  logic [WORD_SIZE-1:0] reg_read_data1,
  // bypass
  input  logic                 fwd_valid,
  input  logic [REG_BITS-1:0]  fwd_addr,
  input  logic [WORD_SIZE-1:0] fwd_data,
  // data memory
  output logic                 memory_req,
  output logic                 memory_write_enable,
  output logic [ADDR_SIZE-1:0] memory_addr,
  output logic [WORD_SIZE-1:0] memory_in,
  input  logic                 memory_ack,
  input  logic [WORD_SIZE-1:0] memory_rdata,
  // downstream
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 no_operation_out,
  output logic [WORD_SIZE-1:0] alu_data0_out,
  output logic [WORD_SIZE-1:0] alu_data1_out,
  output logic [WORD_SIZE-1:0] mem_data_out,
  output logic [WORD_SIZE-1:0] code_word_out,
  output logic [ADDR_SIZE-1:0] ip_out,
  output logic [ADDR_SIZE-1:0] data1_plus_imm_out
);

  localparam int OP_LSB = WORD_SIZE - 4;
  localparam int RX_LSB = OP_LSB - REG_BITS;

  typedef enum logic [1:0] {S_EMPTY, S_MEM, S_FULL} state_t;

  state_t                      r_state, w_next;
  logic [WORD_SIZE-1:0]        r_alu0, r_alu1, r_mem_data, r_code, r_mem_wdata;
  logic [ADDR_SIZE-1:0]        r_ip, r_d1pi, r_mem_addr;
  logic                        r_mem_we, r_is_load, r_flush_pend;

  logic [3:0]                  w_op;
  logic [REG_BITS-1:0]         w_rx, w_ry;
  logic signed [IMM_BITS-1:0]  w_imm;
  logic                        w_is_call, w_is_load, w_is_store, w_is_mem, w_use_ip;
  logic [WORD_SIZE-1:0]        w_opnd0, w_opnd1, w_data1, w_mem_wdata;
  logic [ADDR_SIZE-1:0]        w_d1pi, w_mem_addr, w_ip_inc;
  logic                        w_accept;

  // field decode, top of the word downwards
  assign w_op  = in_code_word[WORD_SIZE-1 -: 4];
  assign w_rx  = in_code_word[OP_LSB-1 -: REG_BITS];
  assign w_ry  = in_code_word[RX_LSB-1 -: REG_BITS];
  assign w_imm = in_code_word[IMM_BITS-1:0];

  assign w_is_call  = (w_op == OP_CALL_IMM14);
  assign w_is_load  = (w_op == OP_LOAD_FROM_MEMORY);
  assign w_is_store = (w_op == OP_WRITE_TO_MEMORY);
  assign w_is_mem   = w_is_call | w_is_load | w_is_store;
  assign w_use_ip   = w_is_call | (w_op == OP_IF);

  // calls push onto the stack, so port 1 reads the stack pointer
  assign reg_read_addr0 = w_rx;
  assign reg_read_addr1 = w_is_call ? REG_BITS'(SP_REG) : w_ry;

  // bypass wins over the register file when it targets the same register
  assign w_opnd0 = (fwd_valid && fwd_addr == reg_read_addr0) ? fwd_data : reg_read_data0;
  assign w_opnd1 = (fwd_valid && fwd_addr == reg_read_addr1) ? fwd_data : reg_read_data1;

  assign w_data1 = w_use_ip ? WORD_SIZE'(in_ip) : w_opnd1;
  // signed immediate is sign-extended by the size cast; sum wraps at ADDR_SIZE
  assign w_d1pi  = ADDR_SIZE'(w_data1) + ADDR_SIZE'(w_imm);

  assign w_ip_inc    = in_ip + ADDR_SIZE'(1);
  assign w_mem_addr  = w_is_call ? ADDR_SIZE'(w_opnd1) : w_d1pi;
  assign w_mem_wdata = w_is_call ? WORD_SIZE'(w_ip_inc) : w_opnd0;

  // flush blocks any new accept in the same cycle
  assign in_ready = !flush && ((r_state == S_EMPTY) || (r_state == S_FULL && out_ready));
  assign w_accept = in_valid && in_ready;

  // next-state: accept dominates; MEM always waits for the ack, even when flushed
  always_comb begin
    w_next = r_state;
    if (w_accept) begin
      w_next = w_is_mem ? S_MEM : S_FULL;
    end else begin
      unique case (r_state)
        S_EMPTY: w_next = S_EMPTY;
        S_MEM:   if (memory_ack) w_next = (r_flush_pend || flush) ? S_EMPTY : S_FULL;
        S_FULL:  if (flush || out_ready) w_next = S_EMPTY;
        default: w_next = S_EMPTY;
      endcase
    end
  end

  // state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_EMPTY;
    else        r_state <= w_next;
  end

  // datapath latches: captured on accept, memory read data captured on ack
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_alu0       <= '0;
      r_alu1       <= '0;
      r_mem_data   <= '0;
      r_code       <= '0;
      r_mem_wdata  <= '0;
      r_ip         <= '0;
      r_d1pi       <= '0;
      r_mem_addr   <= '0;
      r_mem_we     <= 1'b0;
      r_is_load    <= 1'b0;
      r_flush_pend <= 1'b0;
    end else if (w_accept) begin
      r_alu0       <= w_opnd0;
      r_alu1       <= w_data1;
      r_mem_data   <= '0;
      r_code       <= in_code_word;
      r_mem_wdata  <= w_mem_wdata;
      r_ip         <= in_ip;
      r_d1pi       <= w_d1pi;
      r_mem_addr   <= w_mem_addr;
      r_mem_we     <= !w_is_load;
      r_is_load    <= w_is_load;
      r_flush_pend <= 1'b0;
    end else if (r_state == S_MEM) begin
      if (flush) r_flush_pend <= 1'b1;
      if (memory_ack && r_is_load) r_mem_data <= memory_rdata;
    end
  end

  assign memory_req          = (r_state == S_MEM);
  assign memory_write_enable = (r_state == S_MEM) && r_mem_we;
  assign memory_addr         = r_mem_addr;
  assign memory_in           = r_mem_wdata;

  assign out_valid          = (r_state == S_FULL);
  assign no_operation_out   = !out_valid;
  assign alu_data0_out      = r_alu0;
  assign alu_data1_out      = r_alu1;
  assign mem_data_out       = r_mem_data;
  assign code_word_out      = out_valid ? r_code : '0;
  assign ip_out             = r_ip;
  assign data1_plus_imm_out = r_d1pi;

endmodule

// File: tb/tb_processor_operand_stage.sv
// Self-checking bench for processor_operand_stage: directed vector table,
// hand-written multi-cycle sequences, and randomized traffic vs. a reference model.
module tb_processor_operand_stage;
  import processor_operand_stage_pkg::*;

  localparam int AW = 18;
  localparam int WW = 18;
  localparam int AMOD = 1 << AW;

  logic          clock = 1'b0;
  logic          reset;
  logic          in_valid, in_ready, flush;
  logic [AW-1:0] in_ip;
  logic [WW-1:0] in_code_word;
  logic [2:0]    reg_read_addr0, reg_read_addr1;
  logic [WW-1:0] reg_read_data0, reg_read_data1;
  logic          fwd_valid;
  logic [2:0]    fwd_addr;
  logic [WW-1:0] fwd_data;
  logic          memory_req, memory_write_enable, memory_ack;
  logic [AW-1:0] memory_addr;
  logic [WW-1:0] memory_in, memory_rdata;
  logic          out_valid, out_ready, no_operation_out;
  logic [WW-1:0] alu_data0_out, alu_data1_out, mem_data_out, code_word_out;
  logic [AW-1:0] ip_out, data1_plus_imm_out;

  logic [WW-1:0] regs [8];
  int n_chk = 0;
  int n_fail = 0;

  assign reg_read_data0 = regs[reg_read_addr0];
  assign reg_read_data1 = regs[reg_read_addr1];

  always #5 clock = ~clock;

  processor_operand_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_ip(in_ip), .in_code_word(in_code_word),
    .flush(flush),
    .reg_read_addr0(reg_read_addr0), .reg_read_addr1(reg_read_addr1),
    .reg_read_data0(reg_read_data0), .reg_read_data1(reg_read_data1),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .memory_req(memory_req), .memory_write_enable(memory_write_enable),
    .memory_addr(memory_addr), .memory_in(memory_in),
    .memory_ack(memory_ack), .memory_rdata(memory_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .no_operation_out(no_operation_out),
    .alu_data0_out(alu_data0_out), .alu_data1_out(alu_data1_out), .mem_data_out(mem_data_out),
    .code_word_out(code_word_out), .ip_out(ip_out), .data1_plus_imm_out(data1_plus_imm_out)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [WW-1:0] enc(logic [3:0] op, int rx, int ry, int imm);
    return {op, 3'(rx), 3'(ry), 8'(imm)};
  endfunction

  // reference model: expected results from the instruction rules
  typedef struct {
    logic [WW-1:0] alu0, alu1, mwdata;
    logic [AW-1:0] d1pi, maddr;
    bit            mem, we, load;
  } exp_t;

  function automatic exp_t model(logic [WW-1:0] word, logic [AW-1:0] ip);
    exp_t e;
    int op, rx, ry, a1, imm, s;
    int op0, op1, data1;
    op  = int'(word) / (1 << 14);
    rx  = (int'(word) / (1 << 11)) % 8;
    ry  = (int'(word) / (1 << 8)) % 8;
    imm = int'(word) % 256;
    if (imm >= 128) imm -= 256;
    a1  = (op == int'(OP_CALL_IMM14)) ? 7 : ry;
    op0 = (fwd_valid && int'(fwd_addr) == rx) ? int'(fwd_data) : int'(regs[rx]);
    op1 = (fwd_valid && int'(fwd_addr) == a1) ? int'(fwd_data) : int'(regs[a1]);
    data1 = (op == int'(OP_IF) || op == int'(OP_CALL_IMM14)) ? int'(ip) : op1;
    s = data1 + imm;
    if (s < 0) s += AMOD;
    s = s % AMOD;
    e.alu0 = WW'(op0);
    e.alu1 = WW'(data1);
    e.d1pi = AW'(s);
    e.load = (op == int'(OP_LOAD_FROM_MEMORY));
    e.mem  = e.load || op == int'(OP_WRITE_TO_MEMORY) || op == int'(OP_CALL_IMM14);
    e.we   = e.mem && !e.load;
    e.maddr  = (op == int'(OP_CALL_IMM14)) ? AW'(op1) : AW'(s);
    e.mwdata = (op == int'(OP_CALL_IMM14)) ? WW'((int'(ip) + 1) % AMOD) : WW'(op0);
    return e;
  endfunction

  // memory responder: counts request cycles, acks on cycle 'lat', checks stability
  task automatic mem_seq(input string nm, input int lat, input logic [WW-1:0] rdata,
                         input logic [AW-1:0] e_addr, input logic [WW-1:0] e_wdata,
                         input bit e_we);
    int cyc = 0;
    for (int c = 0; c < 40; c++) begin
      if (memory_req !== 1'b1) break;
      cyc++;
      chk({nm, "_addr"}, memory_addr, e_addr);
      chk({nm, "_we"}, memory_write_enable, e_we);
      if (e_we) chk({nm, "_wdata"}, memory_in, e_wdata);
      memory_ack   = (cyc == lat);
      memory_rdata = (cyc == lat) ? rdata : 18'h15A5A;
      step();
      memory_ack = 1'b0;
    end
    chk({nm, "_req_cycles"}, cyc, lat);
    chk({nm, "_req_drop"}, memory_req, 1'b0);
  endtask

  typedef struct {
    logic [3:0]    op;
    int            rx, ry, imm;
    logic [AW-1:0] ip;
    logic [WW-1:0] rxv, ryv;
    bit            fv;
    int            fa;
    logic [WW-1:0] fd;
    logic [WW-1:0] e_alu0, e_alu1;
    logic [AW-1:0] e_d1pi;
  } vec_t;

  vec_t vt [8];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WW-1:0] w, w2;
    exp_t e;
    logic [3:0] ops [7];
    logic [WW-1:0] rd;

    ops = '{OP_REG_ADD_IMM8, OP_IF, OP_NOP, OP_LOAD_FROM_MEMORY,
            OP_WRITE_TO_MEMORY, OP_CALL_IMM14, 4'hF};

    vt[0] = '{OP_REG_ADD_IMM8, 1, 2, -3,   18'h0,     18'd0, 18'd5,       0, 0, 18'd0,  18'd0,  18'd5,       18'd2};
    vt[1] = '{OP_REG_ADD_IMM8, 1, 3, 0,    18'h0,     18'd4, 18'd10,      1, 3, 18'd99, 18'd4,  18'd99,      18'd99};
    vt[2] = '{OP_REG_ADD_IMM8, 3, 2, 5,    18'h0,     18'd10, 18'd20,     1, 3, 18'd77, 18'd77, 18'd20,      18'd25};
    vt[3] = '{OP_REG_ADD_IMM8, 1, 2, 0,    18'h0,     18'd1, 18'd2,       0, 2, 18'd55, 18'd1,  18'd2,       18'd2};
    vt[4] = '{OP_IF,           1, 2, 16,   18'h12345, 18'd9, 18'd33,      0, 0, 18'd0,  18'd9,  18'h12345,   18'h12355};
    vt[5] = '{OP_REG_ADD_IMM8, 1, 2, -2,   18'h0,     18'd0, 18'd1,       0, 0, 18'd0,  18'd0,  18'd1,       18'h3FFFF};
    vt[6] = '{OP_REG_ADD_IMM8, 1, 2, 1,    18'h0,     18'd0, 18'h3FFFF,   0, 0, 18'd0,  18'd0,  18'h3FFFF,   18'h0};
    vt[7] = '{OP_IF,           1, 2, -128, 18'h0,     18'd3, 18'd4,       0, 0, 18'd0,  18'd3,  18'd0,       18'h3FF80};

    for (int i = 0; i < 8; i++) regs[i] = '0;
    reset = 1'b0; in_valid = 0; in_ip = '0; in_code_word = '0; flush = 0;
    fwd_valid = 0; fwd_addr = '0; fwd_data = '0; memory_ack = 0; memory_rdata = '0;
    out_ready = 1'b1;

    // reset state
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_no_op", no_operation_out, 1'b1);
    chk("rst_mem_req", memory_req, 1'b0);
    chk("rst_mem_we", memory_write_enable, 1'b0);
    chk("rst_code", code_word_out, '0);
    chk("rst_alu1", alu_data1_out, '0);
    chk("rst_d1pi", data1_plus_imm_out, '0);
    #11 reset = 1'b1;

    // directed table, back-to-back single-cycle ops
    for (int i = 0; i < 8; i++) begin
      regs[vt[i].rx] = vt[i].rxv;
      regs[vt[i].ry] = vt[i].ryv;
      fwd_valid = vt[i].fv; fwd_addr = 3'(vt[i].fa); fwd_data = vt[i].fd;
      in_ip = vt[i].ip;
      w = enc(vt[i].op, vt[i].rx, vt[i].ry, vt[i].imm);
      in_code_word = w; in_valid = 1'b1;
      step();
      chk($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d_alu0", i), alu_data0_out, vt[i].e_alu0);
      chk($sformatf("tbl%0d_alu1", i), alu_data1_out, vt[i].e_alu1);
      chk($sformatf("tbl%0d_d1pi", i), data1_plus_imm_out, vt[i].e_d1pi);
      chk($sformatf("tbl%0d_code", i), code_word_out, w);
      chk($sformatf("tbl%0d_ip", i), ip_out, vt[i].ip);
    end
    in_valid = 0; fwd_valid = 0;
    step();
    chk("drain_empty", out_valid, 1'b0);

    // store with three wait states; latched operands survive input changes
    regs[1] = 18'd7; regs[2] = 18'h100;
    w = enc(OP_WRITE_TO_MEMORY, 1, 2, 4);
    in_code_word = w; in_valid = 1;
    step();
    in_valid = 0; in_code_word = 18'h3FFFF; regs[1] = 0; regs[2] = 0;
    chk("st_no_valid", out_valid, 1'b0);
    mem_seq("st", 3, 18'h0, 18'h104, 18'd7, 1'b1);
    chk("st_out_valid", out_valid, 1'b1);
    chk("st_code", code_word_out, w);

    // load back-to-back from FULL, read data captured
    regs[2] = 18'h200;
    w = enc(OP_LOAD_FROM_MEMORY, 0, 2, -1);
    in_code_word = w; in_valid = 1;
    step();
    in_valid = 0;
    mem_seq("ld", 2, 18'h2ABCD, 18'h1FF, 18'h0, 1'b0);
    chk("ld_out_valid", out_valid, 1'b1);
    chk("ld_mem_data", mem_data_out, 18'h2ABCD);

    // call: stack pointer address, return address wraps to zero
    regs[7] = 18'h3F0; regs[2] = 18'h55; regs[1] = 18'h11;
    w = enc(OP_CALL_IMM14, 1, 2, 0);
    in_code_word = w; in_ip = 18'h3FFFF; in_valid = 1;
    #1;
    chk("call_rd_addr1", reg_read_addr1, 3'd7);
    step();
    in_valid = 0; in_ip = 18'h1;
    mem_seq("call", 1, 18'h0, 18'h3F0, 18'h0, 1'b1);
    chk("call_out_valid", out_valid, 1'b1);
    chk("call_alu1", alu_data1_out, 18'h3FFFF);

    // backpressure: outputs held, no accept, then no-bubble take-over
    out_ready = 0;
    regs[2] = 18'h20;
    w2 = enc(OP_REG_ADD_IMM8, 1, 2, 1);
    in_code_word = w2; in_valid = 1; in_ip = 18'h40;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("bp_in_ready", in_ready, 1'b0);
      step();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_code", code_word_out, w);
      chk("bp_alu1", alu_data1_out, 18'h3FFFF);
    end
    out_ready = 1;
    #1;
    chk("bp_release_ready", in_ready, 1'b1);
    step();
    chk("bp_new_code", code_word_out, w2);
    chk("bp_new_d1pi", data1_plus_imm_out, 18'h21);

    // flush in FULL, with out_ready low
    out_ready = 0; flush = 1;
    #1;
    chk("fl_in_ready", in_ready, 1'b0);
    step();
    flush = 0; in_valid = 0;
    chk("fl_valid", out_valid, 1'b0);
    chk("fl_no_op", no_operation_out, 1'b1);
    chk("fl_code", code_word_out, '0);

    // flush and out_ready together, with a waiting instruction
    out_ready = 1; in_valid = 1;
    step();
    chk("flr_full", out_valid, 1'b1);
    flush = 1;
    step();
    flush = 0; in_valid = 0;
    chk("flr_empty", out_valid, 1'b0);

    // flush during MEM: handshake completes, nothing delivered
    w = enc(OP_LOAD_FROM_MEMORY, 0, 2, 0);
    in_code_word = w; in_valid = 1;
    step();
    in_valid = 0; flush = 1;
    step();
    flush = 0;
    mem_seq("flm", 2, 18'h1234, 18'h20, 18'h0, 1'b0);
    chk("flm_valid", out_valid, 1'b0);
    step();
    chk("flm_valid2", out_valid, 1'b0);

    // reset during MEM: request drops without a clock edge
    w = enc(OP_WRITE_TO_MEMORY, 1, 2, 0);
    in_code_word = w; in_valid = 1;
    step();
    in_valid = 0;
    chk("rm_req_before", memory_req, 1'b1);
    #2 reset = 0;
    #1;
    chk("rm_req_async", memory_req, 1'b0);
    chk("rm_we_async", memory_write_enable, 1'b0);
    chk("rm_valid", out_valid, 1'b0);
    step();
    reset = 1;
    step();
    chk("rm_empty_ready", in_ready, 1'b1);
    chk("rm_empty_valid", out_valid, 1'b0);
    chk("rm_alu1_zero", alu_data1_out, '0);

    // randomized traffic against the model
    out_ready = 1;
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 8; i++) regs[i] = WW'($urandom_range(0, AMOD - 1));
      fwd_valid = 1'($urandom_range(0, 1));
      fwd_addr  = 3'($urandom_range(0, 7));
      fwd_data  = WW'($urandom_range(0, AMOD - 1));
      in_ip     = AW'($urandom_range(0, AMOD - 1));
      w = enc(ops[$urandom_range(0, 6)], $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 255));
      in_code_word = w; in_valid = 1;
      e = model(w, in_ip);
      w2 = in_ip;
      #1;
      chk("rnd_in_ready", in_ready, 1'b1);
      step();
      in_valid = 0; fwd_valid = 0; in_code_word = 18'h2AAAA; in_ip = 18'h3;
      for (int i = 0; i < 8; i++) regs[i] = '0;
      rd = WW'($urandom_range(0, AMOD - 1));
      if (e.mem) mem_seq("rnd_mem", $urandom_range(1, 4), rd, e.maddr, e.mwdata, e.we);
      chk("rnd_valid", out_valid, 1'b1);
      chk("rnd_alu0", alu_data0_out, e.alu0);
      chk("rnd_alu1", alu_data1_out, e.alu1);
      chk("rnd_d1pi", data1_plus_imm_out, e.d1pi);
      chk("rnd_code", code_word_out, w);
      chk("rnd_ip", ip_out, w2);
      if (e.load) chk("rnd_ld_data", mem_data_out, rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
